// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 8;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int unsigned TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

    // Round-robin pick: a lone requester always wins; on a tie the port
    // that was not served last wins.
    function automatic port_id_e pick_port(input logic i_req,
                                           input logic d_req,
                                           input port_id_e last_served);
        port_id_e pick;
        if (i_req && d_req) begin
            pick = (last_served == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            pick = PORT_D;
        end else begin
            pick = PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave modport; the requesters and memory model use master.
interface mem_arbiter_if #(
    parameter int unsigned N = 64,
    parameter int unsigned A = 32
);
    logic          i_req;
    logic [A-1:0]  i_addr;
    logic [31:0]   i_rdata;
    logic          i_valid;
    logic          i_abort;

    logic          d_req;
    logic          d_we;
    logic [A-1:0]  d_addr;
    logic [N-1:0]  d_wdata;
    logic [N-1:0]  d_rdata;
    logic          d_valid;
    logic          d_err;

    logic          mem_req;
    logic          mem_we;
    logic [A-1:0]  mem_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;
    logic          mem_ready;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_valid, i_abort,
        output d_rdata, d_valid, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_valid, i_abort,
        input  d_rdata, d_valid, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_timer.sv
// BUSY-phase watchdog: a down-counter loaded on clear and decremented while
// enabled. It reaches zero on the TIMEOUT-th enabled cycle after a clear,
// and expired flags that cycle.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LOAD = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    // Load on clear, otherwise count down while enabled and hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory.
// One transaction at a time: grant in IDLE, wait for mem_ready (bounded by
// the timer) in BUSY, pulse the owner's completion in RESP.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no transaction; grant on any request
//   ST_BUSY | mem_req high, waiting for mem_ready or timer expiry
//   ST_RESP | one-cycle valid pulse to the owner, then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N       = 64,
    parameter int unsigned A       = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    arb_state_e state;
    arb_state_e state_next;
    port_id_e   owner;
    port_id_e   pick;

    logic start;
    logic capture;
    logic abort;
    logic busy;
    logic expired;

    // owner doubles as the last-served flag: it only changes on a grant.
    assign pick = pick_port(bus.i_req, bus.d_req, owner);
    assign busy = (state == ST_BUSY);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .enable  (busy),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes; mem_ready beats expiry.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    start      = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else if (expired) begin
                    abort      = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Grant and memory command: latched on grant, held for the whole BUSY phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner         <= PORT_I;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (start) begin
            owner       <= pick;
            bus.mem_req <= 1'b1;
            if (pick == PORT_D) begin
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
            end else begin
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.i_addr;
                bus.mem_wdata <= '0;
            end
        end else if (capture || abort) begin
            bus.mem_req <= 1'b0;
        end
    end

    // Responses: one-cycle valid pulses; read data only updates on a real read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.i_valid <= 1'b0;
            bus.i_abort <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_valid <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= '0;
        end else begin
            bus.i_valid <= 1'b0;
            bus.i_abort <= 1'b0;
            bus.d_valid <= 1'b0;
            bus.d_err   <= 1'b0;
            if (capture || abort) begin
                if (owner == PORT_I) begin
                    bus.i_valid <= 1'b1;
                    bus.i_abort <= abort;
                    if (capture) begin
                        bus.i_rdata <= bus.mem_rdata[31:0];
                    end
                end else begin
                    bus.d_valid <= 1'b1;
                    bus.d_err   <= abort;
                    if (capture && !bus.mem_we) begin
                        bus.d_rdata <= bus.mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// checked every cycle, plus literal spot checks of the key timings.
module tb_mem_arbiter;

    localparam int unsigned N       = 64;
    localparam int unsigned A       = 32;
    localparam int unsigned TIMEOUT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    mem_arbiter_if #(.N(N), .A(A)) bus ();

    mem_arbiter #(
        .N       (N),
        .A       (A),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding transaction record; it finishes on the first cycle
    // memory is ready or once TIMEOUT cycles have been spent waiting, then
    // one response cycle, then the arbiter is free again.
    bit          m_active;
    bit          m_resp;
    bit          m_own_d;
    bit          m_last_d;
    int          m_wait;
    logic        e_mem_req, e_mem_we, e_i_valid, e_i_abort, e_d_valid, e_d_err;
    logic [A-1:0] e_mem_addr;
    logic [N-1:0] e_mem_wdata, e_d_rdata;
    logic [31:0]  e_i_rdata;

    function automatic bit pick_d(input bit i_r, input bit d_r, input bit last_d);
        return d_r && (!i_r || !last_d);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active    <= 1'b0;
            m_resp      <= 1'b0;
            m_own_d     <= 1'b0;
            m_last_d    <= 1'b0;
            m_wait      <= 0;
            e_mem_req   <= 1'b0;
            e_mem_we    <= 1'b0;
            e_mem_addr  <= '0;
            e_mem_wdata <= '0;
            e_i_valid   <= 1'b0;
            e_i_abort   <= 1'b0;
            e_i_rdata   <= '0;
            e_d_valid   <= 1'b0;
            e_d_err     <= 1'b0;
            e_d_rdata   <= '0;
        end else begin
            e_i_valid <= 1'b0;
            e_i_abort <= 1'b0;
            e_d_valid <= 1'b0;
            e_d_err   <= 1'b0;
            if (m_active) begin
                m_wait <= m_wait + 1;
                if (bus.mem_ready || (m_wait + 1 == int'(TIMEOUT))) begin
                    m_active  <= 1'b0;
                    m_resp    <= 1'b1;
                    e_mem_req <= 1'b0;
                    if (m_own_d) begin
                        e_d_valid <= 1'b1;
                        e_d_err   <= !bus.mem_ready;
                        if (bus.mem_ready && !e_mem_we) e_d_rdata <= bus.mem_rdata;
                    end else begin
                        e_i_valid <= 1'b1;
                        e_i_abort <= !bus.mem_ready;
                        if (bus.mem_ready) e_i_rdata <= bus.mem_rdata[31:0];
                    end
                end
            end else if (m_resp) begin
                m_resp <= 1'b0;
            end else if (bus.i_req || bus.d_req) begin
                m_active  <= 1'b1;
                m_wait    <= 0;
                m_own_d   <= pick_d(bus.i_req, bus.d_req, m_last_d);
                m_last_d  <= pick_d(bus.i_req, bus.d_req, m_last_d);
                e_mem_req <= 1'b1;
                if (pick_d(bus.i_req, bus.d_req, m_last_d)) begin
                    e_mem_we    <= bus.d_we;
                    e_mem_addr  <= bus.d_addr;
                    e_mem_wdata <= bus.d_wdata;
                end else begin
                    e_mem_we    <= 1'b0;
                    e_mem_addr  <= bus.i_addr;
                    e_mem_wdata <= '0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("mem_req",   64'(bus.mem_req),   64'(e_mem_req));
        chk("mem_we",    64'(bus.mem_we),    64'(e_mem_we));
        chk("mem_addr",  64'(bus.mem_addr),  64'(e_mem_addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_mem_wdata));
        chk("i_valid",   64'(bus.i_valid),   64'(e_i_valid));
        chk("i_abort",   64'(bus.i_abort),   64'(e_i_abort));
        chk("i_rdata",   64'(bus.i_rdata),   64'(e_i_rdata));
        chk("d_valid",   64'(bus.d_valid),   64'(e_d_valid));
        chk("d_err",     64'(bus.d_err),     64'(e_d_err));
        chk("d_rdata",   64'(bus.d_rdata),   64'(e_d_rdata));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input bit want_d, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = want_d ? bus.d_valid : bus.i_valid;
        end
        chk(want_d ? "wait_d_valid" : "wait_i_valid", 64'(seen), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        repeat (3) tick();

        // Reset values.
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_d_rdata", 64'(bus.d_rdata), 64'd0);

        // Instruction fetch, ready on first BUSY cycle; request right at reset release.
        reset         = 1'b0;
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h40;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h1111_2222_3333_4444;
        chk("t1_no_grant_yet", 64'(bus.mem_req), 64'd0);
        tick();
        chk("t1_mem_req",  64'(bus.mem_req),  64'd1);
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'h40);
        chk("t1_mem_we",   64'(bus.mem_we),   64'd0);
        chk("t1_i_valid_early", 64'(bus.i_valid), 64'd0);
        tick();
        chk("t1_i_valid",  64'(bus.i_valid),  64'd1);
        chk("t1_i_rdata",  64'(bus.i_rdata),  64'h3333_4444);
        chk("t1_i_abort",  64'(bus.i_abort),  64'd0);
        chk("t1_req_drop", 64'(bus.mem_req),  64'd0);
        bus.i_req = 1'b0;
        tick();
        chk("t1_i_pulse_end", 64'(bus.i_valid), 64'd0);

        // Tie after reset: data first, then instruction, twice.
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.i_req     = 1'b1;
        bus.d_req     = 1'b1;
        bus.i_addr    = 32'h80;
        bus.d_addr    = 32'h200;
        bus.d_we      = 1'b0;
        bus.mem_rdata = 64'hCAFE_0001_0000_0002;
        for (int r = 0; r < 2; r++) begin
            bus.i_req = 1'b1;
            bus.d_req = 1'b1;
            tick();
            chk("t2_tie_data_addr", 64'(bus.mem_addr), 64'h200);
            wait_valid(1'b1, 4, n);
            chk("t2_d_latency", 64'(n), 64'd1);
            chk("t2_d_rdata", 64'(bus.d_rdata), 64'hCAFE_0001_0000_0002);
            bus.d_req = 1'b0;
            tick();
            tick();
            chk("t2_then_instr_addr", 64'(bus.mem_addr), 64'h80);
            wait_valid(1'b0, 4, n);
            chk("t2_i_rdata", 64'(bus.i_rdata), 64'h0000_0002);
            bus.i_req = 1'b0;
            tick();
        end

        // Write, memory slow, requester drops d_req mid-transaction.
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h100;
        bus.d_wdata   = 64'hDEAD_BEEF;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 64'h5555_5555_5555_5555;
        tick();
        chk("t3_mem_we",    64'(bus.mem_we),    64'd1);
        chk("t3_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        bus.d_req   = 1'b0;
        bus.d_wdata = 64'h0;
        tick();
        tick();
        chk("t3_wdata_held", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        chk("t3_req_held",   64'(bus.mem_req),   64'd1);
        bus.mem_ready = 1'b1;
        tick();
        chk("t3_d_valid", 64'(bus.d_valid), 64'd1);
        chk("t3_d_err",   64'(bus.d_err),   64'd0);
        chk("t3_rdata_unchanged", 64'(bus.d_rdata), 64'hCAFE_0001_0000_0002);
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Data timeout: ready never comes.
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h300;
        bus.mem_rdata = 64'h7777_8888_9999_AAAA;
        wait_valid(1'b1, 20, n);
        chk("t4_timeout_latency", 64'(n), 64'd9);
        chk("t4_d_err", 64'(bus.d_err), 64'd1);
        chk("t4_rdata_unchanged", 64'(bus.d_rdata), 64'hCAFE_0001_0000_0002);
        bus.d_req = 1'b0;
        tick();

        // Ready arriving on the last allowed BUSY cycle wins over expiry.
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h308;
        repeat (8) tick();
        chk("t4b_still_busy", 64'(bus.mem_req), 64'd1);
        chk("t4b_no_valid",   64'(bus.d_valid), 64'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk("t4b_d_valid", 64'(bus.d_valid), 64'd1);
        chk("t4b_d_err",   64'(bus.d_err),   64'd0);
        chk("t4b_d_rdata", 64'(bus.d_rdata), 64'h7777_8888_9999_AAAA);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Instruction timeout.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h44;
        wait_valid(1'b0, 20, n);
        chk("t4c_timeout_latency", 64'(n), 64'd9);
        chk("t4c_i_abort", 64'(bus.i_abort), 64'd1);
        chk("t4c_i_rdata", 64'(bus.i_rdata), 64'h0000_0002);
        bus.i_req = 1'b0;
        tick();

        // Reset in the second BUSY cycle of a data access.
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h400;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t5_mem_req_async", 64'(bus.mem_req),  64'd0);
        chk("t5_mem_addr_async", 64'(bus.mem_addr), 64'd0);
        bus.d_req = 1'b0;
        tick();
        chk("t5_no_d_valid", 64'(bus.d_valid), 64'd0);
        reset         = 1'b0;
        bus.i_req     = 1'b1;
        bus.d_req     = 1'b1;
        bus.i_addr    = 32'h500;
        bus.d_addr    = 32'h600;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("t5_tie_to_data", 64'(bus.mem_addr), 64'h600);
        wait_valid(1'b1, 4, n);
        bus.d_req = 1'b0;
        wait_valid(1'b0, 6, n);
        chk("t5_i_rdata", 64'(bus.i_rdata), 64'h89AB_CDEF);
        bus.i_req = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
